// File: rtl/wb_timer.sv
// wb_timer: Wishbone B4 pipelined slave, 32-bit up-counter with compare match, overflow flag and level irq.
// Latency: every request accepted on the cyc&stb edge, ack exactly one clk later; read data sampled pre-write.
// Backpressure: none, stall is tied low; optional prescaler enabled by defining WB_TIMER_PRESCALER_EN.
module wb_timer #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_9200,
    parameter logic [31:0] RST_CMP   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_data_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_data_o,
    output logic        wbs_ack_o,
    output logic        wbs_stall_o,
    output logic        irq_o
);

    logic        ack_q;
    logic        en, irq_en, auto_reload, one_shot;
    logic [31:0] count, cmp;
    logic        match, ovf;
    logic [15:0] presc;

    logic        accept, wr_en;
    logic        wr_ctrl, wr_count, wr_cmp, wr_status;
    logic [31:0] wmask, ctrl_rd, ctrl_wr_val, rd_mux;
    logic        tick, match_set, ovf_set, en_clr;
    logic [31:0] count_nxt;

    assign accept      = wbs_cyc_i & wbs_stb_i;
    assign wr_en       = accept & wbs_we_i;
    assign wr_ctrl     = wr_en && (wbs_addr_i[3:2] == 2'd0);
    assign wr_count    = wr_en && (wbs_addr_i[3:2] == 2'd1);
    assign wr_cmp      = wr_en && (wbs_addr_i[3:2] == 2'd2);
    assign wr_status   = wr_en && (wbs_addr_i[3:2] == 2'd3);
    assign wmask       = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign ctrl_rd     = {presc, 12'd0, one_shot, auto_reload, irq_en, en};
    assign ctrl_wr_val = (ctrl_rd & ~wmask) | (wbs_data_i & wmask);
    assign wbs_stall_o = 1'b0;
    assign wbs_ack_o   = ack_q & wbs_cyc_i;

`ifdef WB_TIMER_PRESCALER_EN
    logic [15:0] pre_cnt;

    // Prescaler divides the tick to one every PRESC+1 clks; restarts on disable or CTRL write
    always_ff @(posedge clk) begin
        if (rst || !en || wr_ctrl || (pre_cnt == presc)) pre_cnt <= 16'd0;
        else                                              pre_cnt <= pre_cnt + 16'd1;
    end

    // PRESC field lives in CTRL[31:16]
    always_ff @(posedge clk) begin
        if (rst)          presc <= 16'd0;
        else if (wr_ctrl) presc <= ctrl_wr_val[31:16];
    end

    assign tick = en && (pre_cnt == presc);

    logic unused_ok;
    assign unused_ok = ^{ADDR_BASE, wbs_addr_i[31:4], wbs_addr_i[1:0], ctrl_wr_val[15:4]};
`else
    assign presc = 16'd0;
    assign tick  = en;

    logic unused_ok;
    assign unused_ok = ^{ADDR_BASE, wbs_addr_i[31:4], wbs_addr_i[1:0], ctrl_wr_val[31:4]};
`endif

    // Register read mux, always the state before this edge's write
    always_comb begin
        rd_mux = 32'd0;
        case (wbs_addr_i[3:2])
            2'd0:    rd_mux = ctrl_rd;
            2'd1:    rd_mux = count;
            2'd2:    rd_mux = cmp;
            default: rd_mux = {30'd0, ovf, match};
        endcase
    end

    // Tick evaluation: next count, flag set requests and one-shot disable
    always_comb begin
        count_nxt = count;
        match_set = 1'b0;
        ovf_set   = 1'b0;
        en_clr    = 1'b0;
        if (tick) begin
            count_nxt = count + 32'd1;
            if (count == cmp) begin
                match_set = 1'b1;
                en_clr    = one_shot;
                if (auto_reload) count_nxt = 32'd0;
            end
            if ((count == 32'hFFFF_FFFF) && !((count == cmp) && auto_reload)) ovf_set = 1'b1;
        end
    end

    // Timer state: bus writes take priority over tick updates, flag sets beat W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            one_shot    <= 1'b0;
            count       <= 32'd0;
            cmp         <= RST_CMP;
            match       <= 1'b0;
            ovf         <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en          <= ctrl_wr_val[0];
                irq_en      <= ctrl_wr_val[1];
                auto_reload <= ctrl_wr_val[2];
                one_shot    <= ctrl_wr_val[3];
            end else if (en_clr) begin
                en <= 1'b0;
            end
            count <= wr_count ? ((count & ~wmask) | (wbs_data_i & wmask)) : count_nxt;
            if (wr_cmp) cmp <= (cmp & ~wmask) | (wbs_data_i & wmask);
            match <= match_set | (match & ~(wr_status & wbs_sel_i[0] & wbs_data_i[0]));
            ovf   <= ovf_set   | (ovf   & ~(wr_status & wbs_sel_i[0] & wbs_data_i[1]));
            irq_o <= irq_en & (match | ovf);
        end
    end

    // Bus response: one ack per accept, read data captured at the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            wbs_data_o <= 32'd0;
        end else begin
            ack_q <= accept;
            if (accept) wbs_data_o <= rd_mux;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed register-level test of wb_timer with hand-computed expectations.
// Each bus op occupies exactly one clk edge, so consecutive ops are back-to-back pipelined accepts.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_wb_timer;

    localparam logic [31:0] BASE = 32'h0000_9200;
    localparam logic [3:0] O_CTRL = 4'h0, O_COUNT = 4'h4, O_CMP = 4'h8, O_STATUS = 4'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdat = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] rdat_o;
    logic        ack_o, stall_o, irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] tmp;

    wb_timer #(.ADDR_BASE(BASE), .RST_CMP(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_addr_i(addr), .wbs_data_i(wdat), .wbs_sel_i(sel),
        .wbs_data_o(rdat_o), .wbs_ack_o(ack_o), .wbs_stall_o(stall_o), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accept on the next edge; checks ack and stall, returns the captured read data
    task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        cyc = 1'b1; stb = 1'b1; we = w; addr = BASE + {28'd0, off}; wdat = d; sel = s;
        @(posedge clk); #1;
        check("ack", {31'd0, ack_o}, 32'd1);
        check("stall", {31'd0, stall_o}, 32'd0);
        r = rdat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, off, d, 4'hF, r);
    endtask

    task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, off, 32'd0, 4'hF, r);
        check(tag, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_data", rdat_o, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd("rst_ctrl", O_CTRL, 32'd0);
        rd("rst_count", O_COUNT, 32'd0);
        rd("rst_cmp", O_CMP, 32'hFFFF_FFFF);
        rd("rst_status", O_STATUS, 32'd0);
        idle(1);
        check("idle_ack", {31'd0, ack_o}, 32'd0);

        // Compare match with irq, W1C, count continues, write beats tick
        wr(O_CMP, 32'd5);
        wr(O_CTRL, 32'h3);                 // edge B
        idle(6);                           // B+6: MATCH set here
        check("irq_lag", {31'd0, irq}, 32'd0);
        idle(1);                           // B+7
        check("irq_rise", {31'd0, irq}, 32'd1);
        rd("match_status", O_STATUS, 32'h1);  // B+8
        wr(O_STATUS, 32'h1);               // B+9
        check("irq_hold", {31'd0, irq}, 32'd1);
        idle(1);                           // B+10
        check("irq_clear", {31'd0, irq}, 32'd0);
        rd("count_cont", O_COUNT, 32'd10); // B+11
        wr(O_COUNT, 32'd100);              // B+12, tick also pending
        rd("write_wins", O_COUNT, 32'd100);

        // One-shot auto-reload: 0,1,2,3,0 then hold
        wr(O_CTRL, 32'h0);
        wr(O_COUNT, 32'h0);
        wr(O_CMP, 32'd3);
        wr(O_STATUS, 32'h3);
        wr(O_CTRL, 32'hD);                 // edge D
        rd("os_c0", O_COUNT, 32'd0);
        rd("os_c1", O_COUNT, 32'd1);
        rd("os_c2", O_COUNT, 32'd2);
        rd("os_c3", O_COUNT, 32'd3);
        rd("os_c4", O_COUNT, 32'd0);
        rd("os_hold", O_COUNT, 32'd0);
        rd("os_ctrl", O_CTRL, 32'hC);
        rd("os_status", O_STATUS, 32'h1);

        // Overflow
        wr(O_CTRL, 32'h0);
        wr(O_STATUS, 32'h3);
        wr(O_CMP, 32'd7);
        wr(O_COUNT, 32'hFFFF_FFFE);
        wr(O_CTRL, 32'h1);
        rd("ovf_c0", O_COUNT, 32'hFFFF_FFFE);
        rd("ovf_c1", O_COUNT, 32'hFFFF_FFFF);
        rd("ovf_wrap", O_COUNT, 32'h0);
        rd("ovf_status", O_STATUS, 32'h2);
        check("ovf_noirq", {31'd0, irq}, 32'd0);

        // Byte lanes, sel=0, read-before-write
        wr(O_CTRL, 32'h0);
        wr(O_COUNT, 32'h0);
        bus(1'b1, O_COUNT, 32'hABCD_1234, 4'b0011, tmp);
        rd("sel_lanes", O_COUNT, 32'h0000_1234);
        bus(1'b1, O_CMP, 32'h0000_FFFF, 4'b0000, tmp);
        rd("sel_zero", O_CMP, 32'd7);
        bus(1'b1, O_COUNT, 32'h55, 4'hF, tmp);
        check("rd_pre_wr", tmp, 32'h0000_1234);
        rd("wr_applied", O_COUNT, 32'h55);

        // CTRL upper half: prescaler or ignored
        wr(O_COUNT, 32'h0);
        wr(O_CTRL, 32'h0004_0001);         // edge K
`ifdef WB_TIMER_PRESCALER_EN
        rd("ctrl_presc", O_CTRL, 32'h0004_0001);
        idle(4);
        rd("presc_count", O_COUNT, 32'd1);
`else
        rd("ctrl_presc", O_CTRL, 32'h0000_0001);
        idle(4);
        rd("presc_count", O_COUNT, 32'd5);
`endif
        wr(O_CTRL, 32'h0);

        // cyc dropped before second ack
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = BASE + 32'h4; sel = 4'hF;
        @(posedge clk); #1;
        check("abort_ack1", {31'd0, ack_o}, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        #1 check("abort_ack2", {31'd0, ack_o}, 32'd0);
        @(posedge clk); #1;
        check("abort_idle", {31'd0, ack_o}, 32'd0);

        // Request in the reset cycle is dropped
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = BASE; wdat = 32'h1; sel = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; stb = 1'b0; we = 1'b0;
        #1 check("rst_drop_ack", {31'd0, ack_o}, 32'd0);
        @(posedge clk); #1;
        check("rst_drop_ack2", {31'd0, ack_o}, 32'd0);
        cyc = 1'b0;
        rd("rst2_ctrl", O_CTRL, 32'd0);
        rd("rst2_cmp", O_CMP, 32'hFFFF_FFFF);
        rd("rst2_count", O_COUNT, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
